approx_ctrl: RTL and testbench

//  Control FSM that sequences the approximation datapath: on a host request it pulses start,

---
 rtl/approx_pkg.sv | 31 +++
 rtl/approx_op_timer.sv | 35 +++
 rtl/approx_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_approx_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/approx_pkg.sv
// Shared constants for the approximation controller and its datapath:
// ALU mode codes, controller state encodings and the register-load length.
package approx_pkg;

  // ALU operation codes, shared with the datapath ALU
  localparam logic [2:0] MODE_PASS = 3'd0;
  localparam logic [2:0] MODE_SUB1 = 3'd1;
  localparam logic [2:0] MODE_MUL  = 3'd2;
  localparam logic [2:0] MODE_ACC  = 3'd3;
  localparam logic [2:0] MODE_INC  = 3'd4;

  // Controller state encodings
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_LOAD  = 4'd2;
  localparam logic [3:0] S_X1    = 4'd3;
  localparam logic [3:0] S_X1N   = 4'd4;
  localparam logic [3:0] S_TERM  = 4'd5;
  localparam logic [3:0] S_POW   = 4'd6;
  localparam logic [3:0] S_INC   = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  // Cycles the datapath needs after start to register its inputs
  localparam int LOAD_CYC = 2;

  // True for states that issue an ALU micro-op
  function automatic logic is_op_state(input logic [3:0] s);
    return (s == S_X1) || (s == S_X1N) || (s == S_TERM) || (s == S_POW) || (s == S_INC);
  endfunction

endpackage

// File: rtl/approx_op_timer.sv
// Down-counter that times one micro-op (ALU_LAT+1 cycles) or the register
// load phase (LOAD_CYC cycles); last_o marks the final cycle of either.
module approx_op_timer
  import approx_pkg::*;
#(
  parameter int ALU_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ld_op_i,
  input  logic ld_seq_i,
  output logic last_o
);

  localparam int MAXV = (ALU_LAT > LOAD_CYC - 1) ? ALU_LAT : LOAD_CYC - 1;
  localparam int CW   = $clog2(MAXV + 1);

  logic [CW-1:0] cnt_q;

  // Load the remaining-cycle count on phase entry, then count down to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (ld_op_i) begin
      cnt_q <= CW'(ALU_LAT);
    end else if (ld_seq_i) begin
      cnt_q <= CW'(LOAD_CYC - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/approx_ctrl.sv
// Control FSM for the approximation datapath: accepts a host request, pulses
// start, sequences the X1/X1N set-up ops and the TERM/POW/INC loop until the
// datapath reports a termination match, then holds the result flag.
// Optional build macro: APPROX_CTRL_WATCHDOG_EN (abort after 8 unmatched INCs).
module approx_ctrl
  import approx_pkg::*;
#(
  parameter int ALU_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [2:0] numIt_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       err_o,
  input  logic       dp_valid_i,
  output logic       start_o,
  output logic       check_term_o,
  output logic [2:0] mode_o,
  output logic       wren_x1_o,
  output logic       wren_x1_n_o,
  output logic       wren_x1_n_mult_o,
  output logic       wren_y_o,
  output logic       wren_n_o,
  output logic       wren_sigma_n_o,
  output logic       x_to_alu_a_o,
  output logic       y_to_alu_a_o,
  output logic       x1_to_alu_a_o,
  output logic       n_to_alu_a_o,
  output logic       x1_n_to_alu_b_o,
  output logic       sigma_n_to_alu_o
);

  logic [3:0] state_q, state_d;
  logic       err_q, err_d;
  logic       op_last;
  logic       ld_op, ld_seq;
  logic       wd_trip;

  // Reload the timer whenever a new op or the load phase is entered
  assign ld_op  = (state_d != state_q) && is_op_state(state_d);
  assign ld_seq = (state_d == S_LOAD) && (state_q != S_LOAD);

  approx_op_timer #(.ALU_LAT(ALU_LAT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .ld_op_i  (ld_op),
    .ld_seq_i (ld_seq),
    .last_o   (op_last)
  );

`ifdef APPROX_CTRL_WATCHDOG_EN
  logic [2:0] wd_q, wd_d;

  // Count completed INC ops that did not produce a termination match
  always_comb begin
    wd_d = wd_q;
    if (state_q == S_IDLE) begin
      wd_d = '0;
    end else if ((state_q == S_INC) && op_last && !dp_valid_i) begin
      wd_d = wd_q + 3'd1;
    end
  end

  // Watchdog count register
  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end

  // Seven unmatched INCs already seen: this is the eighth
  assign wd_trip = (wd_q == 3'd7);
`else
  assign wd_trip = 1'b0;
`endif

  // Next-state and completion-status logic
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          // n starts at 1, so targets 0 and 1 can never be matched
          if (numIt_i < 3'd2) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_START;
            err_d   = 1'b0;
          end
        end
      end
      S_START: state_d = S_LOAD;
      S_LOAD:  if (op_last) state_d = S_X1;
      S_X1:    if (op_last) state_d = S_X1N;
      S_X1N:   if (op_last) state_d = S_TERM;
      S_TERM:  if (op_last) state_d = S_POW;
      S_POW:   if (op_last) state_d = S_INC;
      S_INC: begin
        if (op_last) begin
          if (dp_valid_i) begin
            state_d = S_DONE;
            err_d   = 1'b0;
          end else if (wd_trip) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_TERM;
          end
        end
      end
      S_DONE:  if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Decode datapath controls: selects and mode for the whole op, writes on its last cycle
  always_comb begin
    mode_o           = MODE_PASS;
    x_to_alu_a_o     = 1'b0;
    y_to_alu_a_o     = 1'b0;
    x1_to_alu_a_o    = 1'b0;
    n_to_alu_a_o     = 1'b0;
    x1_n_to_alu_b_o  = 1'b0;
    sigma_n_to_alu_o = 1'b0;
    wren_x1_o        = 1'b0;
    wren_x1_n_o      = 1'b0;
    wren_x1_n_mult_o = 1'b0;
    wren_y_o         = 1'b0;
    wren_n_o         = 1'b0;
    wren_sigma_n_o   = 1'b0;
    check_term_o     = 1'b0;
    case (state_q)
      S_X1: begin
        x_to_alu_a_o = 1'b1;
        mode_o       = MODE_SUB1;
        wren_x1_o    = op_last;
      end
      S_X1N: begin
        x1_to_alu_a_o = 1'b1;
        mode_o        = MODE_PASS;
        wren_x1_n_o   = op_last;
      end
      S_TERM: begin
        y_to_alu_a_o     = 1'b1;
        x1_n_to_alu_b_o  = 1'b1;
        sigma_n_to_alu_o = 1'b1;
        mode_o           = MODE_ACC;
        wren_y_o         = op_last;
      end
      S_POW: begin
        x1_to_alu_a_o    = 1'b1;
        x1_n_to_alu_b_o  = 1'b1;
        mode_o           = MODE_MUL;
        wren_x1_n_mult_o = op_last;
      end
      S_INC: begin
        n_to_alu_a_o   = 1'b1;
        mode_o         = MODE_INC;
        wren_n_o       = op_last;
        wren_sigma_n_o = op_last;
        check_term_o   = op_last;
      end
      default: ;
    endcase
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign start_o     = (state_q == S_START);
  assign out_valid_o = (state_q == S_DONE);
  assign err_o       = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_approx_ctrl.sv
// Self-checking bench for approx_ctrl: reset state, a vector table of
// transactions, randomized transactions against a cycle-count model,
// reset abort mid-loop, and the watchdog / unbounded-loop corner.
module tb_approx_ctrl;

  localparam int ALU_LAT = 2;
  localparam int OPC     = ALU_LAT + 1;

  logic       clk = 1'b0;
  logic       rst, in_valid_i, out_ready_i, dp_valid_i;
  logic [2:0] numIt_i;
  logic       in_ready_o, out_valid_o, err_o, start_o, check_term_o;
  logic [2:0] mode_o;
  logic       wren_x1_o, wren_x1_n_o, wren_x1_n_mult_o, wren_y_o, wren_n_o, wren_sigma_n_o;
  logic       x_to_alu_a_o, y_to_alu_a_o, x1_to_alu_a_o, n_to_alu_a_o, x1_n_to_alu_b_o, sigma_n_to_alu_o;

  approx_ctrl #(.ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .numIt_i(numIt_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .err_o(err_o),
    .dp_valid_i(dp_valid_i), .start_o(start_o), .check_term_o(check_term_o), .mode_o(mode_o),
    .wren_x1_o(wren_x1_o), .wren_x1_n_o(wren_x1_n_o), .wren_x1_n_mult_o(wren_x1_n_mult_o),
    .wren_y_o(wren_y_o), .wren_n_o(wren_n_o), .wren_sigma_n_o(wren_sigma_n_o),
    .x_to_alu_a_o(x_to_alu_a_o), .y_to_alu_a_o(y_to_alu_a_o), .x1_to_alu_a_o(x1_to_alu_a_o),
    .n_to_alu_a_o(n_to_alu_a_o), .x1_n_to_alu_b_o(x1_n_to_alu_b_o), .sigma_n_to_alu_o(sigma_n_to_alu_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // pulse counters and protocol-violation count, maintained by the monitor
  int n_start = 0, n_x1 = 0, n_x1n = 0, n_y = 0, n_mult = 0, n_n = 0;
  int mon_viol = 0;

  // datapath stand-in: report a match on the match_k-th INC of the transaction
  int inc_base = 0;
  int match_k  = 0;
  assign dp_valid_i = check_term_o && ((n_n - inc_base) == match_k);

  logic [8:0] sig, sig1, sig2;
  logic [5:0] wr, wr1, wr2, wr_exp;
  assign sig = {x_to_alu_a_o, y_to_alu_a_o, x1_to_alu_a_o, n_to_alu_a_o,
                x1_n_to_alu_b_o, sigma_n_to_alu_o, mode_o};
  assign wr  = {wren_x1_o, wren_x1_n_o, wren_x1_n_mult_o, wren_y_o, wren_n_o, wren_sigma_n_o};

  // Monitor: count pulses and flag any micro-op protocol violation
  always @(negedge clk) begin
    if (start_o)          n_start++;
    if (wren_x1_o)        n_x1++;
    if (wren_x1_n_o)      n_x1n++;
    if (wren_y_o)         n_y++;
    if (wren_x1_n_mult_o) n_mult++;
    if (wren_n_o)         n_n++;
    if (check_term_o != wren_n_o)     mon_viol++;
    if (wren_sigma_n_o != wren_n_o)   mon_viol++;
    if ($countones(sig[8:5]) > 1)     mon_viol++;
    if ((sig[8:5] == 4'b0) && (mode_o != 3'd0)) mon_viol++;
    if (wr != 6'b0) begin
      case (mode_o)
        3'd1:    wr_exp = 6'b100000;
        3'd0:    wr_exp = x1_to_alu_a_o ? 6'b010000 : 6'b111111;
        3'd2:    wr_exp = 6'b001000;
        3'd3:    wr_exp = 6'b000100;
        3'd4:    wr_exp = 6'b000011;
        default: wr_exp = 6'b111111;
      endcase
      if (wr != wr_exp) mon_viol++;
      if ((sig != sig1) || (sig != sig2)) mon_viol++;
      if ((wr1 != 6'b0) || (wr2 != 6'b0)) mon_viol++;
    end
    sig2 = sig1; sig1 = sig;
    wr2  = wr1;  wr1  = wr;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: edges after the accept edge until the result is flagged
  function automatic int ref_latency(input int numit, input int k);
    if (numit < 2) return 0;
    return 1 + 2 + 2 * OPC + k * 3 * OPC;
  endfunction

  // One full host transaction, including a held-result phase with a competing request
  task automatic run_txn(input int numit, input int k, input int rdy, input int exp_lat,
                         input int exp_err, input int exp_start, input int exp_loops,
                         input string tag);
    int lat, b_start, b_x1, b_y, b_mult, held_bad, viol0;
    chk($sformatf("%s ready", tag), int'(in_ready_o), 1);
    b_start = n_start; b_x1 = n_x1; b_y = n_y; b_mult = n_mult; viol0 = mon_viol;
    inc_base = n_n; match_k = k;
    in_valid_i = 1'b1; numIt_i = numit[2:0];
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    lat = 0;
    while (!out_valid_o && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s latency", tag), lat, exp_lat);
    chk($sformatf("%s err", tag), int'(err_o), exp_err);
    chk($sformatf("%s busy", tag), int'(in_ready_o), 0);
    held_bad = 0;
    in_valid_i = 1'b1; numIt_i = 3'd3;
    for (int i = 0; i < rdy; i++) begin
      @(posedge clk); #1;
      if (!out_valid_o || in_ready_o || start_o || (int'(err_o) != exp_err)) held_bad++;
    end
    in_valid_i = 1'b0;
    chk($sformatf("%s held", tag), held_bad, 0);
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    chk($sformatf("%s released", tag), int'(out_valid_o), 0);
    chk($sformatf("%s idle", tag), int'(in_ready_o), 1);
    chk($sformatf("%s starts", tag), n_start - b_start, exp_start);
    chk($sformatf("%s x1 writes", tag), n_x1 - b_x1, exp_start);
    chk($sformatf("%s y writes", tag), n_y - b_y, exp_loops);
    chk($sformatf("%s mult writes", tag), n_mult - b_mult, exp_loops);
    chk($sformatf("%s inc writes", tag), n_n - inc_base, exp_loops);
    chk($sformatf("%s protocol", tag), mon_viol - viol0, 0);
  endtask

  typedef struct {
    int numit; int k; int rdy; int lat; int err; int starts; int loops;
  } vec_t;

  vec_t vecs[6];

  // Hard bound on the whole run
  initial begin
    #300000;
    $display("FAIL global timeout: checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int wait_cnt, numit, k, rdy;
    vecs[0] = '{3, 2, 0, 27, 0, 1, 2};
    vecs[1] = '{1, 2, 0,  0, 1, 0, 0};
    vecs[2] = '{0, 1, 2,  0, 1, 0, 0};
    vecs[3] = '{2, 1, 5, 18, 0, 1, 1};
    vecs[4] = '{5, 4, 1, 45, 0, 1, 4};
    vecs[5] = '{7, 6, 3, 63, 0, 1, 6};

    rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0; numIt_i = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", int'(in_ready_o), 1);
    chk("reset out_valid", int'(out_valid_o), 0);
    chk("reset err", int'(err_o), 0);
    chk("reset start", int'(start_o), 0);
    chk("reset controls", int'({wr, sig, check_term_o}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].numit, vecs[i].k, vecs[i].rdy, vecs[i].lat, vecs[i].err,
              vecs[i].starts, vecs[i].loops, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      numit = $urandom_range(0, 7);
      k     = $urandom_range(1, 5);
      rdy   = $urandom_range(0, 3);
      run_txn(numit, k, rdy, ref_latency(numit, k), (numit < 2) ? 1 : 0,
              (numit < 2) ? 0 : 1, (numit < 2) ? 0 : k, $sformatf("rnd%0d", i));
    end

    // reset while a TERM op is in progress
    inc_base = n_n; match_k = 2;
    in_valid_i = 1'b1; numIt_i = 3'd3;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    wait_cnt = 0;
    while (!y_to_alu_a_o && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk("abort reached TERM", int'(y_to_alu_a_o), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort controls", int'({wr, sig, check_term_o, start_o}), 0);
    chk("abort in_ready", int'(in_ready_o), 1);
    chk("abort out_valid", int'(out_valid_o), 0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort stays idle", int'({out_valid_o, in_ready_o, start_o}), 3'b010);

    // no termination match at all
`ifdef APPROX_CTRL_WATCHDOG_EN
    run_txn(3, 0, 2, 1 + 2 + 2 * OPC + 8 * 3 * OPC, 1, 1, 8, "watchdog");
`else
    inc_base = n_n; match_k = 0;
    in_valid_i = 1'b1; numIt_i = 3'd3;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    wait_cnt = 0;
    while ((n_n - inc_base) < 8 && wait_cnt < 200) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk("nowd eight incs", n_n - inc_base, 8);
    repeat (4) @(posedge clk);
    #1;
    chk("nowd still looping", int'(out_valid_o), 0);
    chk("nowd busy", int'(in_ready_o), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("nowd reset idle", int'(in_ready_o), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
